// File: rtl/board_input_conditioner.sv
// Per-channel conditioner for raw board pins: synchroniser, optional inversion,
// optional debounce, and single-cycle rise/fall pulses on the conditioned level.
module board_input_conditioner #(
    parameter int              N_CH            = 4,
    parameter int              SYNC_STAGES     = 2,
    parameter int              DEBOUNCE_CYCLES = 650000,
    parameter logic [N_CH-1:0] INVERT_MASK     = '0,
    parameter logic [N_CH-1:0] BYPASS_MASK     = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] in_raw,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] busy
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [N_CH-1:0] sync_q [SYNC_STAGES];
    logic [N_CH-1:0] s;
    logic [CW-1:0]   cnt_q  [N_CH];
    logic [CW-1:0]   cnt_d  [N_CH];
    logic [N_CH-1:0] level_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= in_raw;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    // Inversion is applied after the chain so every pin sees identical sync timing.
    assign s = sync_q[SYNC_STAGES-1] ^ INVERT_MASK;

    always_comb begin
        level_d = level;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = '0;
            if (BYPASS_MASK[i]) begin
                level_d[i] = s[i];
            end else if (s[i] != level[i]) begin
                // Flip on the D-th consecutive disagreeing cycle; any agreeing cycle restarts.
                if (cnt_q[i] == CNT_LAST) level_d[i] = s[i];
                else                      cnt_d[i]   = cnt_q[i] + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
            rise  <= '0;
            fall  <= '0;
            busy  <= '0;
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
        end else begin
            level <= level_d;
            rise  <= level_d & ~level;
            fall  <= ~level_d & level;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                busy[i]  <= (cnt_d[i] != '0);
            end
        end
    end
endmodule
